// File: rtl/hc21_ste_pkg.sv
// Shared types and STE command encodings for the HC21 STE bus master.
package hc21_ste_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        RELEASE
    } ste_state_t;

    localparam logic [2:0] CM_IDLE = 3'b000;
    localparam logic [2:0] CM_MEM  = 3'b111;
    localparam logic [2:0] CM_IO   = 3'b101;
    localparam logic [2:0] CM_IACK = 3'b010;

endpackage

// File: rtl/hc21_sync_n.sv
// Multi-stage synchroniser for an active-low asynchronous input; resets to inactive (high).
module hc21_sync_n #(
    parameter int unsigned NumStages = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_n_i,
    output logic sync_n_o
);

    logic [NumStages-1:0] sync_q;
    logic [NumStages-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[NumStages-2:0], async_n_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_n_o = sync_q[NumStages-1];

endmodule

// File: rtl/hc21_ste_bus_master.sv
// Z80-to-STE bus master: decodes off-board cycles and runs the STE strobe/acknowledge handshake.
module hc21_ste_bus_master
    import hc21_ste_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES   = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       sysclk,
    input  logic       sysrst,
    input  logic       cpu_rfsh_n,
    input  logic       cpu_m1_n,
    input  logic       cpu_rd_n,
    input  logic       cpu_wr_n,
    input  logic       cpu_mreq_n,
    input  logic       cpu_iorq_n,
    input  logic       onboard_n,
    input  logic       datack_n,
    input  logic       tfrerr_n,
    input  logic       err_clr,
    output logic       cpu_wait_n,
    output logic [2:0] cm,
    output logic       busstb_n,
    output logic       bufout,
    output logic       intack,
    output logic       buserr,
    output logic       err_sticky
);

    localparam int unsigned ToW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ToW-1:0] ToLast = ToW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [ToW-1:0] ToMax  = '1;

    ste_state_t     state_q, state_d;
    logic [3:0]     setup_cnt_q, setup_cnt_d;
    logic [ToW-1:0] to_cnt_q, to_cnt_d;
    logic [2:0]     cm_q, cm_d;
    logic           busstb_n_q, busstb_n_d;
    logic           bufout_q, bufout_d;
    logic           intack_q, intack_d;
    logic           buserr_q, buserr_d;
    logic           err_sticky_q, err_sticky_d;

    logic req, iack, ack_sync_n, err_sync_n, timeout_hit;

    hc21_sync_n #(.NumStages(SYNC_STAGES)) u_sync_ack (
        .clk_i     (sysclk),
        .rst_i     (sysrst),
        .async_n_i (datack_n),
        .sync_n_o  (ack_sync_n)
    );

    hc21_sync_n #(.NumStages(SYNC_STAGES)) u_sync_err (
        .clk_i     (sysclk),
        .rst_i     (sysrst),
        .async_n_i (tfrerr_n),
        .sync_n_o  (err_sync_n)
    );

    // Refresh cycles drive mreq_n low too; rfsh_n gating keeps them off the backplane.
    assign req = onboard_n &
                 ((~cpu_mreq_n & cpu_rfsh_n & (~cpu_rd_n | ~cpu_wr_n)) |
                  (~cpu_iorq_n & (~cpu_rd_n | ~cpu_wr_n | ~cpu_m1_n)));
    assign iack = ~cpu_iorq_n & ~cpu_m1_n;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt_q == ToLast);

    always_comb begin
        state_d      = state_q;
        setup_cnt_d  = setup_cnt_q;
        to_cnt_d     = to_cnt_q;
        cm_d         = cm_q;
        busstb_n_d   = busstb_n_q;
        bufout_d     = bufout_q;
        intack_d     = intack_q;
        buserr_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d     = SETUP;
                    setup_cnt_d = 4'(SETUP_CYCLES - 1);
                    bufout_d    = ~cpu_wr_n;
                    intack_d    = iack;
                    if (iack) begin
                        cm_d = CM_IACK;
                    end else if (~cpu_iorq_n) begin
                        cm_d = CM_IO;
                    end else begin
                        cm_d = CM_MEM;
                    end
                end
            end
            SETUP: begin
                if (setup_cnt_q == 4'd0) begin
                    state_d    = STROBE;
                    busstb_n_d = 1'b0;
                    to_cnt_d   = '0;
                end else begin
                    setup_cnt_d = setup_cnt_q - 4'd1;
                end
            end
            STROBE: begin
                if (to_cnt_q != ToMax) begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
                // Abort first, then error (beats a simultaneous ack), then timeout, then ack.
                if (!req) begin
                    state_d    = RELEASE;
                    busstb_n_d = 1'b1;
                end else if (!err_sync_n || timeout_hit) begin
                    state_d    = RELEASE;
                    busstb_n_d = 1'b1;
                    buserr_d   = 1'b1;
                end else if (!ack_sync_n) begin
                    state_d    = RELEASE;
                    busstb_n_d = 1'b1;
                end
            end
            RELEASE: begin
                if (!req && ack_sync_n) begin
                    state_d  = IDLE;
                    cm_d     = CM_IDLE;
                    bufout_d = 1'b0;
                    intack_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (buserr_d) begin
            err_sticky_d = 1'b1;
        end else if (err_clr) begin
            err_sticky_d = 1'b0;
        end else begin
            err_sticky_d = err_sticky_q;
        end
    end

    always_ff @(posedge sysclk) begin
        if (sysrst) begin
            state_q      <= IDLE;
            setup_cnt_q  <= '0;
            to_cnt_q     <= '0;
            cm_q         <= CM_IDLE;
            busstb_n_q   <= 1'b1;
            bufout_q     <= 1'b0;
            intack_q     <= 1'b0;
            buserr_q     <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            setup_cnt_q  <= setup_cnt_d;
            to_cnt_q     <= to_cnt_d;
            cm_q         <= cm_d;
            busstb_n_q   <= busstb_n_d;
            bufout_q     <= bufout_d;
            intack_q     <= intack_d;
            buserr_q     <= buserr_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    // WAIT goes low combinationally so the Z80 is held in the same cycle the request appears.
    assign cpu_wait_n = ~(req & (state_q == IDLE)) & ~((state_q == SETUP) | (state_q == STROBE));
    assign cm         = cm_q;
    assign busstb_n   = busstb_n_q;
    assign bufout     = bufout_q;
    assign intack     = intack_q;
    assign buserr     = buserr_q;
    assign err_sticky = err_sticky_q;

endmodule
